io_bus_fabric: RTL and testbench

//  Parametrised MMIO fabric between the CPU mem port and N peripheral slaves (UART, CLINT, SPI, GPIO, SYSCON...).

---
 rtl/io_bus_fabric_pkg.sv | 27 ++
 rtl/io_bus_fabric_addr_decode.sv | 31 +++
 rtl/io_bus_fabric.sv | 164 ++++++++++++++++
 tb/tb_io_bus_fabric.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_fabric_pkg.sv
// Shared types and helpers for the MMIO fabric.
//   fab_state_e    : transaction FSM state encoding
//   addr_in_window : inclusive range check of an address against [lo, hi]
//   mask_hit       : base/mask match of one slave slot
package io_bus_fabric_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_UNMAP = 3'd2,
    ST_RESP  = 3'd3,
    ST_TURN  = 3'd4
  } fab_state_e;

  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  function automatic logic mask_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/io_bus_fabric_addr_decode.sv
// Combinational priority address decode for the MMIO fabric.
//   addr_i    : byte address to decode
//   sel_o     : one-hot slave select, lowest matching index wins
//   any_hit_o : at least one slave matched
module io_bus_fabric_addr_decode
  import io_bus_fabric_pkg::*;
#(
  parameter int                        NUM_SLAVES = 8,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK = {NUM_SLAVES{32'hFFFF_FFFC}}
) (
  input  logic [31:0]           addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  any_hit_o
);

  // Walk from the highest index down so the lowest matching slot is the
  // last one written and therefore wins.
  always_comb begin
    sel_o     = '0;
    any_hit_o = 1'b0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (mask_hit(addr_i, SLAVE_BASE[32*k +: 32], SLAVE_MASK[32*k +: 32])) begin
        sel_o     = '0;
        sel_o[k]  = 1'b1;
        any_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_fabric.sv
// MMIO fabric between the CPU memory port and NUM_SLAVES peripherals.
// One transaction at a time: registered decode, one-hot slave strobe held
// until the selected slave readies, per-access timeout, optional fault on
// unmapped in-window accesses.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   cpu_valid_i/addr/wstrb/wdata : CPU request, held until cpu_ready_o
//   cpu_ready_o/rdata/fault   : one-cycle completion with response
//   s_valid_o/addr/wdata/wstrb : one-hot strobe and registered request copy
//   s_rdata_i, s_ready_i      : per-slave read data and completion
//   busy_o                    : FSM not idle
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for an in-window cpu_valid
// ST_REQ   | strobing the selected slave, timeout counter running
// ST_UNMAP | in-window address with no slave, build zero response
// ST_RESP  | cpu_ready pulse with latched rdata/fault
// ST_TURN  | dead cycle so a still-held cpu_valid is not re-accepted
module io_bus_fabric
  import io_bus_fabric_pkg::*;
#(
  parameter int                        NUM_SLAVES     = 8,
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {NUM_SLAVES{32'hFFFF_FFFC}},
  parameter logic [31:0]               IO_BASE        = 32'h1000_0000,
  parameter logic [31:0]               IO_LIMIT       = 32'h1200_0000,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter bit                        UNMAPPED_FAULT = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_valid_i,
  input  logic [31:0]             cpu_addr_i,
  input  logic [3:0]              cpu_wstrb_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic                    cpu_ready_o,
  output logic [31:0]             cpu_rdata_o,
  output logic                    cpu_fault_o,
  output logic [NUM_SLAVES-1:0]   s_valid_o,
  output logic [31:0]             s_addr_o,
  output logic [31:0]             s_wdata_o,
  output logic [3:0]              s_wstrb_o,
  input  logic [32*NUM_SLAVES-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]   s_ready_i,
  output logic                    busy_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  fab_state_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    fault_q, fault_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;

  io_bus_fabric_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr_i    (cpu_addr_i),
    .sel_o     (dec_sel),
    .any_hit_o (dec_hit)
  );

  // sel_q is one-hot, so masking and OR-ing gives the selected slot only;
  // readies from other slaves are dropped here.
  assign sel_ready = |(s_ready_i & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q[k]) sel_rdata = sel_rdata | s_rdata_i[32*k +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cpu_valid_i && addr_in_window(cpu_addr_i, IO_BASE, IO_LIMIT)) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          wstrb_d = cpu_wstrb_i;
          sel_d   = dec_sel;
          state_d = dec_hit ? ST_REQ : ST_UNMAP;
        end
      end
      ST_REQ: begin
        // A ready in the expiry cycle still counts as a good completion.
        if (sel_ready) begin
          rdata_d = (wstrb_q == 4'b0000) ? sel_rdata : 32'h0;
          fault_d = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 32'h0;
          fault_d = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UNMAP: begin
        rdata_d = 32'h0;
        fault_d = UNMAPPED_FAULT;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_ready_o = (state_q == ST_RESP);
  assign cpu_rdata_o = cpu_ready_o ? rdata_q : 32'h0;
  assign cpu_fault_o = cpu_ready_o & fault_q;
  assign s_valid_o   = (state_q == ST_REQ) ? sel_q : '0;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_wstrb_o   = wstrb_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_io_bus_fabric.sv
// Scoreboard bench for io_bus_fabric. Two instances share all inputs and
// differ only in UNMAPPED_FAULT; both use a timeout of 8 cycles.
// Slot map: 0 @1000_0000/FFFFFFFC, 1 @1000_0040/FFFFFFF0,
//           2 @1000_0010/FFFFFFFC, 3 @1000_0000/FFFFFF00 (overlaps 0..2).
module tb_io_bus_fabric;

  localparam int NS = 4;
  localparam logic [32*NS-1:0] BASES =
    {32'h1000_0000, 32'h1000_0010, 32'h1000_0040, 32'h1000_0000};
  localparam logic [32*NS-1:0] MASKS =
    {32'hFFFF_FF00, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFFC};

  typedef struct {
    logic [31:0] rd;
    logic        f;
    int          cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_valid;
  logic [31:0]     cpu_addr;
  logic [3:0]      cpu_wstrb;
  logic [31:0]     cpu_wdata;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;

  logic            ready0, fault0, busy0;
  logic [31:0]     rdata0, saddr0, swdata0;
  logic [3:0]      swstrb0;
  logic [NS-1:0]   sv0;
  logic            ready1, fault1, busy1;
  logic [31:0]     rdata1, saddr1, swdata1;
  logic [3:0]      swstrb1;
  logic [NS-1:0]   sv1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  io_bus_fabric #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS),
    .IO_BASE(32'h1000_0000), .IO_LIMIT(32'h1200_0000),
    .TIMEOUT_CYCLES(8), .UNMAPPED_FAULT(1'b0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst),
    .cpu_valid_i(cpu_valid), .cpu_addr_i(cpu_addr), .cpu_wstrb_i(cpu_wstrb), .cpu_wdata_i(cpu_wdata),
    .cpu_ready_o(ready0), .cpu_rdata_o(rdata0), .cpu_fault_o(fault0),
    .s_valid_o(sv0), .s_addr_o(saddr0), .s_wdata_o(swdata0), .s_wstrb_o(swstrb0),
    .s_rdata_i(s_rdata), .s_ready_i(s_ready), .busy_o(busy0)
  );

  io_bus_fabric #(
    .NUM_SLAVES(NS), .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS),
    .IO_BASE(32'h1000_0000), .IO_LIMIT(32'h1200_0000),
    .TIMEOUT_CYCLES(8), .UNMAPPED_FAULT(1'b1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_valid_i(cpu_valid), .cpu_addr_i(cpu_addr), .cpu_wstrb_i(cpu_wstrb), .cpu_wdata_i(cpu_wdata),
    .cpu_ready_o(ready1), .cpu_rdata_o(rdata1), .cpu_fault_o(fault1),
    .s_valid_o(sv1), .s_addr_o(saddr1), .s_wdata_o(swdata1), .s_wstrb_o(swstrb1),
    .s_rdata_i(s_rdata), .s_ready_i(s_ready), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: every cpu_ready must match the oldest expectation.
  always @(negedge clk) begin
    if (ready0) begin
      if (q0.size() == 0) chk_eq("dut0/unexpected_ready", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        chk_eq("dut0/rdata", rdata0, e0.rd);
        chk_eq("dut0/fault", {31'd0, fault0}, {31'd0, e0.f});
        chk_eq("dut0/latency", 32'(cyc), 32'(e0.cyc));
      end
    end
    if (ready1) begin
      if (q1.size() == 0) chk_eq("dut1/unexpected_ready", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk_eq("dut1/rdata", rdata1, e1.rd);
        chk_eq("dut1/fault", {31'd0, fault1}, {31'd0, e1.f});
        chk_eq("dut1/latency", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  // sidx < 0: unmapped. lat < 0: slave never readies. lat counts REQ cycles
  // before s_ready is raised. stray >= 0 pulses that slave's ready once.
  task automatic run_txn(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int sidx, input int lat, input int stray,
                         input logic [31:0] sdata, input logic [31:0] exp_rd,
                         input logic exp_f0, input logic exp_f1);
    exp_t e;
    int   t0;
    int   eff;
    int   n_sv;
    bit   seen;
    logic [31:0] exp_sv;
    for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = 32'hC0DE_0000 | 32'(k);
    if (sidx >= 0) s_rdata[32*sidx +: 32] = sdata;
    exp_sv = (sidx >= 0) ? (32'd1 << sidx) : 32'd0;
    if (sidx < 0) eff = 0;
    else if (lat < 0 || lat > 7) eff = 7;
    else eff = lat;

    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    cpu_wstrb = wstrb;
    cpu_wdata = wdata;
    t0 = cyc + 1;
    e.rd = exp_rd; e.f = exp_f0; e.cyc = t0 + 1 + eff;
    q0.push_back(e);
    e.f = exp_f1;
    q1.push_back(e);

    n_sv = 0;
    seen = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      s_ready = '0;
      if (ready0) begin
        seen = 1'b1;
        break;
      end
      if (i == 0) begin
        chk_eq({name, "/s_valid"}, 32'(sv0), exp_sv);
        chk_eq({name, "/s_addr"}, saddr0, addr);
        chk_eq({name, "/s_wdata"}, swdata0, wdata);
        chk_eq({name, "/s_wstrb"}, 32'(swstrb0), 32'(wstrb));
      end
      if (sv0 != '0) n_sv++;
      if (sidx >= 0 && i == lat) s_ready[sidx] = 1'b1;
      if (stray >= 0 && i == 0) s_ready[stray] = 1'b1;
      @(negedge clk);
    end
    if (!seen) begin
      chk_eq({name, "/ready_timeout"}, 32'd0, 32'd1);
      cpu_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q0.delete();
      q1.delete();
      return;
    end
    chk_eq({name, "/s_valid_cycles"}, 32'(n_sv), (sidx >= 0) ? 32'(eff + 1) : 32'd0);
    chk_eq({name, "/s_valid_drop"}, 32'(sv0), 32'd0);
    @(negedge clk);
    chk_eq({name, "/single_pulse"}, {31'd0, ready0}, 32'd0);
    chk_eq({name, "/busy_turn"}, {31'd0, busy0}, 32'd1);
    // cpu_valid stays high across the TURN->IDLE edge.
    @(negedge clk);
    chk_eq({name, "/idle"}, {31'd0, busy0}, 32'd0);
    cpu_valid = 1'b0;
    cpu_wstrb = 4'b0000;
    @(negedge clk);
    chk_eq({name, "/no_reaccept"}, {31'd0, busy0}, 32'd0);
  endtask

  task automatic run_ignored(input string name, input logic [31:0] addr);
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    cpu_wstrb = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_eq({name, "/busy"}, {31'd0, busy0}, 32'd0);
      chk_eq({name, "/s_valid"}, 32'(sv0), 32'd0);
    end
    cpu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_wstrb = '0;
    cpu_wdata = '0;
    s_ready   = '0;
    s_rdata   = '0;
    repeat (3) @(negedge clk);
    chk_eq("reset/ready", {31'd0, ready0}, 32'd0);
    chk_eq("reset/rdata", rdata0, 32'd0);
    chk_eq("reset/fault", {31'd0, fault0}, 32'd0);
    chk_eq("reset/s_valid", 32'(sv0), 32'd0);
    chk_eq("reset/s_addr", saddr0, 32'd0);
    chk_eq("reset/busy", {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("read_s2", 32'h1000_0010, 4'b0000, 32'h0, 2, 3, -1,
            32'hA5A5_1234, 32'hA5A5_1234, 1'b0, 1'b0);
    run_txn("write_s0", 32'h1000_0000, 4'b0001, 32'h0000_0055, 0, 1, -1,
            32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    run_txn("unmapped", 32'h1100_0000, 4'b0000, 32'h0, -1, -1, -1,
            32'h0, 32'h0, 1'b0, 1'b1);
    run_txn("limit_unmapped", 32'h1200_0000, 4'b0000, 32'h0, -1, -1, -1,
            32'h0, 32'h0, 1'b0, 1'b1);
    run_ignored("above_limit", 32'h1200_0004);
    run_ignored("below_base", 32'h0FFF_FFFC);
    run_txn("timeout", 32'h1000_0010, 4'b0000, 32'h0, 2, -1, -1,
            32'h7777_8888, 32'h0, 1'b1, 1'b1);
    run_txn("ready_at_expiry", 32'h1000_0010, 4'b0000, 32'h0, 2, 7, -1,
            32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b0);
    run_txn("overlap", 32'h1000_0040, 4'b0000, 32'h0, 1, 2, 3,
            32'h4040_4040, 32'h4040_4040, 1'b0, 1'b0);
    run_txn("write_s2", 32'h1000_0012, 4'b1100, 32'hDEAD_BEEF, 2, 5, -1,
            32'h1111_2222, 32'h0, 1'b0, 1'b0);

    // Reset while the slave is being strobed: abort, no completion.
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = 32'h1000_0000;
    cpu_wstrb = 4'b0000;
    @(negedge clk);
    chk_eq("rst_mid/s_valid_before", 32'(sv0), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    cpu_valid = 1'b0;
    @(negedge clk);
    chk_eq("rst_mid/s_valid", 32'(sv0), 32'd0);
    chk_eq("rst_mid/busy", {31'd0, busy0}, 32'd0);
    chk_eq("rst_mid/ready", {31'd0, ready0}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn("after_reset", 32'h1000_0044, 4'b0000, 32'h0, 1, 0, -1,
            32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk_eq("dut0/leftover", 32'(q0.size()), 32'd0);
    chk_eq("dut1/leftover", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
